wash_cycle_sequencer: RTL and testbench

- Top-level phase controller for the washing-machine unit.
- Accepts a coin/start request and steps through fill, wash, rinse and spin.
- For each phase it loads the timer block with that phase's duration code, then waits for the timer's trigger.
- Adds an optional double-wash pass, a spin-only pause, and a watchdog that forces a safe error state if a phase never completes.

---
 rtl/wash_cycle_sequencer_if.sv | 24 ++
 rtl/wash_cycle_sequencer.sv | 153 +++++++++++++++
 tb/tb_wash_cycle_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wash_cycle_sequencer_if.sv
// rtl/wash_cycle_sequencer_if.sv - sequencer-to-timer handshake bundle
interface wash_cycle_sequencer_if;
    logic       Trigger_clk_timer;
    logic [2:0] Duration_clk_timer;
    logic [1:0] CLK_freq;
    logic       Timer_pause;
    logic       timer_load;

    modport master (
        input  Trigger_clk_timer,
        output Duration_clk_timer,
        output CLK_freq,
        output Timer_pause,
        output timer_load
    );

    modport slave (
        output Trigger_clk_timer,
        input  Duration_clk_timer,
        input  CLK_freq,
        input  Timer_pause,
        input  timer_load
    );
endinterface

// File: rtl/wash_cycle_sequencer.sv
// rtl/wash_cycle_sequencer.sv - wash phase sequencer with timer load, pause and watchdog
module wash_cycle_sequencer #(
    parameter logic [2:0]  DUR_IDLE    = 3'b000,
    parameter logic [2:0]  DUR_FILL    = 3'b001,
    parameter logic [2:0]  DUR_WASH    = 3'b010,
    parameter logic [2:0]  DUR_RINSE   = 3'b011,
    parameter logic [2:0]  DUR_SPIN    = 3'b100,
    parameter logic [31:0] WDOG_CYCLES = 32'd1000000000
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        coin_in,
    input  logic                        double_wash,
    input  logic [1:0]                  CLK_freq_sel,
    input  logic                        pause_req,
    wash_cycle_sequencer_if.master      tmr,
    output logic [2:0]                  phase,
    output logic                        wash_done,
    output logic                        fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  dur_q, dur_d;
    logic [1:0]  freq_q, freq_d;
    logic        pause_q, pause_d;
    logic        load_q, load_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        dbl_q, dbl_d;
    logic        pass_q, pass_d;
    logic [1:0]  blank_q, blank_d;
    logic [31:0] wdog_q, wdog_d;

    logic armed, trig_hit, wdog_hit, entry;

    function automatic logic is_phase(input state_t s);
        return (s == S_FILL) || (s == S_WASH) || (s == S_RINSE) || (s == S_SPIN);
    endfunction

    always_comb begin
        state_d = state_q;
        dbl_d   = dbl_q;
        pass_d  = pass_q;
        freq_d  = freq_q;
        wdog_d  = wdog_q;
        blank_d = (blank_q != 2'd0) ? blank_q - 2'd1 : blank_q;
        dur_d   = DUR_IDLE;

        // The timer may still show the previous phase's trigger for two cycles after a load
        armed    = is_phase(state_q) && (blank_q == 2'd0);
        trig_hit = armed && tmr.Trigger_clk_timer;
        wdog_hit = armed && !pause_q && (wdog_q == WDOG_CYCLES - 32'd1);
        if (armed && !pause_q) begin
            wdog_d = wdog_q + 32'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (coin_in) begin
                    state_d = S_FILL;
                    dbl_d   = double_wash;
                    freq_d  = CLK_freq_sel;
                    pass_d  = 1'b0;
                end
            end
            S_FILL:  if (trig_hit) state_d = S_WASH;
            S_WASH:  if (trig_hit) state_d = S_RINSE;
            S_RINSE: begin
                if (trig_hit) begin
                    if (dbl_q && !pass_q) begin
                        state_d = S_WASH;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_SPIN;
                    end
                end
            end
            S_SPIN:  if (trig_hit) state_d = S_DONE;
            default: state_d = state_q;
        endcase

        // A trigger landing on the watchdog limit cycle still advances normally
        if (wdog_hit && !trig_hit) begin
            state_d = S_ERROR;
        end

        entry = (state_d != state_q) && is_phase(state_d);
        if (entry) begin
            wdog_d  = 32'd0;
            blank_d = 2'd2;
        end

        case (state_d)
            S_FILL:  dur_d = DUR_FILL;
            S_WASH:  dur_d = DUR_WASH;
            S_RINSE: dur_d = DUR_RINSE;
            S_SPIN:  dur_d = DUR_SPIN;
            default: dur_d = DUR_IDLE;
        endcase

        load_d  = entry;
        pause_d = pause_req && (state_d == S_SPIN);
        done_d  = (state_d == S_DONE);
        fault_d = (state_d == S_ERROR);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            dur_q   <= DUR_IDLE;
            freq_q  <= 2'b00;
            pause_q <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            dbl_q   <= 1'b0;
            pass_q  <= 1'b0;
            blank_q <= 2'd0;
            wdog_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            freq_q  <= freq_d;
            pause_q <= pause_d;
            load_q  <= load_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            dbl_q   <= dbl_d;
            pass_q  <= pass_d;
            blank_q <= blank_d;
            wdog_q  <= wdog_d;
        end
    end

    assign phase                  = state_q;
    assign wash_done              = done_q;
    assign fault                  = fault_q;
    assign tmr.Duration_clk_timer = dur_q;
    assign tmr.CLK_freq           = freq_q;
    assign tmr.Timer_pause        = pause_q;
    assign tmr.timer_load         = load_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// tb/tb_wash_cycle_sequencer.sv - directed bench for wash_cycle_sequencer
`timescale 1ns/1ps
module tb_wash_cycle_sequencer;

    logic       clk;
    logic       rst;
    logic       coin_in;
    logic       double_wash;
    logic [1:0] clk_freq_sel;
    logic       pause_req;
    logic [2:0] phase;
    logic       wash_done;
    logic       fault;

    wash_cycle_sequencer_if tif ();

    wash_cycle_sequencer #(.WDOG_CYCLES(32'd50)) dut (
        .CLK          (clk),
        .RST          (rst),
        .coin_in      (coin_in),
        .double_wash  (double_wash),
        .CLK_freq_sel (clk_freq_sel),
        .pause_req    (pause_req),
        .tmr          (tif.master),
        .phase        (phase),
        .wash_done    (wash_done),
        .fault        (fault)
    );

    int checks = 0;
    int errors = 0;

    logic       auto_en = 1'b1;
    logic       man_trig = 1'b0;
    int         cnt = 100;
    int         nload = 0;
    logic [2:0] dur_log [0:63];
    int         exp_seq [0:5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench timer model: raise the trigger 10 cycles after each timer_load
    always @(negedge clk) begin
        if (tif.timer_load) begin
            if (nload < 64) dur_log[nload] = tif.Duration_clk_timer;
            nload = nload + 1;
        end
        if (auto_en) begin
            if (tif.timer_load) cnt = 0;
            else cnt = cnt + 1;
            tif.Trigger_clk_timer = (cnt == 10);
        end else begin
            tif.Trigger_clk_timer = man_trig;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input string tag, input logic [2:0] p, input int max, output int n);
        n = 0;
        while (phase !== p && n < max) begin
            tick();
            n++;
        end
        check(tag, phase, p);
    endtask

    task automatic start_coin(input logic dbl, input logic [1:0] sel);
        coin_in      = 1'b1;
        double_wash  = dbl;
        clk_freq_sel = sel;
        tick();
        coin_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        coin_in = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got 0 exp 1");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int base;
        rst = 1'b0;
        coin_in = 1'b0;
        double_wash = 1'b0;
        clk_freq_sel = 2'b00;
        pause_req = 1'b0;
        do_reset();

        check("rst_phase", phase, 3'd0);
        check("rst_dur", tif.Duration_clk_timer, 3'd0);
        check("rst_freq", tif.CLK_freq, 2'b00);
        check("rst_pause", tif.Timer_pause, 1'b0);
        check("rst_load", tif.timer_load, 1'b0);
        check("rst_done", wash_done, 1'b0);
        check("rst_fault", fault, 1'b0);

        // Single cycle
        base = nload;
        start_coin(1'b0, 2'b10);
        check("t1_fill_load", tif.timer_load, 1'b1);
        check("t1_fill_dur", tif.Duration_clk_timer, 3'd1);
        wait_phase("t1_done", 3'd5, 200, n);
        check("t1_cycles", n, 44);
        check("t1_loads", nload - base, 4);
        exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 4;
        for (int i = 0; i < 4; i++) check("t1_seq", dur_log[base + i], exp_seq[i]);
        check("t1_wash_done", wash_done, 1'b1);
        check("t1_done_dur", tif.Duration_clk_timer, 3'd0);
        check("t1_freq", tif.CLK_freq, 2'b10);

        // Double wash, restarting from DONE, double_wash dropped mid-FILL
        base = nload;
        start_coin(1'b1, 2'b01);
        check("t2_done_clr", wash_done, 1'b0);
        repeat (3) tick();
        double_wash = 1'b0;
        wait_phase("t2_done", 3'd5, 200, n);
        check("t2_cycles", n + 3, 66);
        check("t2_loads", nload - base, 6);
        exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3;
        exp_seq[3] = 2; exp_seq[4] = 3; exp_seq[5] = 4;
        for (int i = 0; i < 6; i++) check("t2_seq", dur_log[base + i], exp_seq[i]);
        check("t2_wash_done", wash_done, 1'b1);

        // Stale trigger held across FILL->WASH
        auto_en = 1'b0;
        man_trig = 1'b0;
        start_coin(1'b0, 2'b00);
        repeat (3) tick();
        man_trig = 1'b1;
        wait_phase("t3_wash", 3'd2, 20, n);
        tick();
        check("t3_wash_c1", phase, 3'd2);
        man_trig = 1'b0;
        tick();
        check("t3_wash_c2", phase, 3'd2);
        repeat (5) tick();
        check("t3_wash_hold", phase, 3'd2);
        man_trig = 1'b1;
        tick();
        man_trig = 1'b0;
        check("t3_rinse", phase, 3'd3);

        // Pause
        do_reset();
        auto_en = 1'b1;
        pause_req = 1'b1;
        start_coin(1'b0, 2'b00);
        wait_phase("t4_wash", 3'd2, 40, n);
        repeat (2) tick();
        check("t4_wash_nopause", tif.Timer_pause, 1'b0);
        pause_req = 1'b0;
        wait_phase("t4_spin", 3'd4, 60, n);
        auto_en = 1'b0;
        man_trig = 1'b0;
        repeat (3) tick();
        pause_req = 1'b1;
        @(negedge clk);
        check("t4_pause_lat", tif.Timer_pause, 1'b0);
        tick();
        check("t4_pause_on", tif.Timer_pause, 1'b1);
        repeat (60) tick();
        check("t4_pause_spin", phase, 3'd4);
        check("t4_pause_nofault", fault, 1'b0);
        pause_req = 1'b0;
        tick();
        check("t4_pause_off", tif.Timer_pause, 1'b0);
        man_trig = 1'b1;
        tick();
        man_trig = 1'b0;
        check("t4_done", phase, 3'd5);

        // Watchdog expiry in RINSE
        do_reset();
        auto_en = 1'b1;
        start_coin(1'b0, 2'b00);
        wait_phase("t5_rinse", 3'd3, 40, n);
        auto_en = 1'b0;
        man_trig = 1'b0;
        wait_phase("t5_error", 3'd6, 200, n);
        check("t5_wdog_cycles", n, 52);
        check("t5_fault", fault, 1'b1);
        check("t5_dur", tif.Duration_clk_timer, 3'd0);
        check("t5_pause", tif.Timer_pause, 1'b0);
        coin_in = 1'b1;
        repeat (2) tick();
        coin_in = 1'b0;
        check("t5_coin_ignored", phase, 3'd6);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t5_rst_phase", phase, 3'd0);
        check("t5_rst_fault", fault, 1'b0);

        // Reset mid-SPIN, reset beats a simultaneous coin
        auto_en = 1'b1;
        start_coin(1'b0, 2'b11);
        wait_phase("t6_spin", 3'd4, 60, n);
        auto_en = 1'b0;
        man_trig = 1'b0;
        pause_req = 1'b1;
        repeat (3) tick();
        check("t6_freq", tif.CLK_freq, 2'b11);
        check("t6_pause", tif.Timer_pause, 1'b1);
        rst = 1'b0;
        coin_in = 1'b1;
        clk_freq_sel = 2'b01;
        tick();
        check("t6_rst_phase", phase, 3'd0);
        check("t6_rst_dur", tif.Duration_clk_timer, 3'd0);
        check("t6_rst_freq", tif.CLK_freq, 2'b00);
        check("t6_rst_pause", tif.Timer_pause, 1'b0);
        check("t6_rst_load", tif.timer_load, 1'b0);
        check("t6_rst_done", wash_done, 1'b0);
        check("t6_rst_fault", fault, 1'b0);
        rst = 1'b1;
        pause_req = 1'b0;
        tick();
        coin_in = 1'b0;
        check("t6_new_phase", phase, 3'd1);
        check("t6_new_freq", tif.CLK_freq, 2'b01);
        check("t6_new_load", tif.timer_load, 1'b1);
        check("t6_new_dur", tif.Duration_clk_timer, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
